// File: rtl/jk_cnt_pkg.sv
// Shared types and parameter checks for the JK-cell modulo counter.
// Used by jk_cell and jk_mod_counter (JK_MOD_CNT_DOWN_EN enables down counting in the top).
package jk_cnt_pkg;

    // JK command as {j, k}
    typedef logic [1:0] jk_cmd_t;

    localparam jk_cmd_t JK_HOLD = 2'b00;
    localparam jk_cmd_t JK_RST  = 2'b01;
    localparam jk_cmd_t JK_SET  = 2'b10;
    localparam jk_cmd_t JK_TGL  = 2'b11;

    // The modulus must fit in the counter and leave at least two states
    function automatic bit cnt_params_ok(input int unsigned width, input int unsigned modulus);
        return (modulus >= 2) && ($clog2(modulus) <= int'(width));
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop bit cell with asynchronous active-high reset.
module jk_cell
    import jk_cnt_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_n
);

    jk_cmd_t cmd;
    logic    q_nxt;

    always_comb begin
        cmd   = {j, k};
        q_nxt = q;
        case (cmd)
            JK_HOLD: q_nxt = q;
            JK_RST:  q_nxt = 1'b0;
            JK_SET:  q_nxt = 1'b1;
            JK_TGL:  q_nxt = ~q;
        endcase
    end

    // q_n is kept as its own flop so both rails come straight off storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= 1'b0;
            q_n <= 1'b1;
        end else begin
            q   <= q_nxt;
            q_n <= ~q_nxt;
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Loadable modulo-MODULUS counter built from JK bit cells, with terminal-count and wrap pulse.
// Define JK_MOD_CNT_DOWN_EN to add the up_dn port and down counting.
module jk_mod_counter
    import jk_cnt_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef JK_MOD_CNT_DOWN_EN
    input  logic             up_dn,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam int unsigned   CW   = WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

    if (!cnt_params_ok(WIDTH, MODULUS)) begin : g_param_err
        $error("jk_mod_counter: MODULUS must be in 2..2**WIDTH");
    end

    logic             dir_up;
    logic [CW-1:0]    q_ext;
    logic [CW-1:0]    ld_ext;
    logic             at_top;
    logic             at_bot;
    logic [WIDTH-1:0] nxt;
    logic             wrap_nxt;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;

`ifdef JK_MOD_CNT_DOWN_EN
    assign dir_up = up_dn;
`else
    assign dir_up = 1'b1;
`endif

    // Compare in WIDTH+1 bits; out-of-range counts are treated as terminal
    assign q_ext  = {1'b0, q};
    assign ld_ext = {1'b0, load_val};
    assign at_top = (q_ext >= LAST);
    assign at_bot = (q_ext == '0) || (q_ext > LAST);

    always_comb begin
        nxt      = q;
        wrap_nxt = 1'b0;
        if (load) begin
            nxt = (ld_ext > LAST) ? WIDTH'(LAST) : load_val;
        end else if (en) begin
            if (dir_up) begin
                if (at_top) begin
                    nxt      = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = WIDTH'(q_ext + CW'(1));
                end
            end else begin
                if (at_bot) begin
                    nxt      = WIDTH'(LAST);
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = WIDTH'(q_ext - CW'(1));
                end
            end
        end
    end

    assign tc = en & ~load & (dir_up ? (q_ext == LAST) : (q_ext == '0));

    // Excitation: set bits that must rise, reset bits that must fall, else hold
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        assign j_vec[i] = nxt[i] & q_n[i];
        assign k_vec[i] = ~nxt[i] & q[i];

        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j_vec[i]),
            .k   (k_vec[i]),
            .q   (q[i]),
            .q_n (q_n[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_nxt;
        end
    end

endmodule
